seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width, legal range 4..64.
REQ-002 SHALL have parameter MUL_EN, default 1; when 1, op 14 is a multi-cycle multiply; when 0, op 14 behaves as reserved.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operation this cycle.
REQ-007 SHALL have port op, input, 4, the operation code.
REQ-008 SHALL have ports x and y, input, WIDTH each, the operands.
REQ-009 SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port result, output, WIDTH, the registered result.
REQ-012 SHALL have ports zero, neg, carry, ovf, output, 1 each, the registered flags.

Function
REQ-013 Opcodes SHALL be: 0 x+y; 1 x-y; 2 y-x; 3 -x; 4 -y; 5 ~x; 6 ~y; 7 x+1; 8 y+1; 9 x-1; 10 y-1; 11 x&y; 12 x|y; 13 x^y; 14 low WIDTH bits of unsigned x*y; 15 reserved, giving result 0.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH in two's complement.
REQ-015 States SHALL be IDLE, MUL and DONE; out_valid SHALL be 1 exactly in DONE.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
REQ-017 An operation SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-018 Non-multiply ops SHALL have 1-cycle latency: on the accepting edge, result and flags are registered and the state goes to DONE.
REQ-019 Op 14 with MUL_EN=1 SHALL go from the accepting edge to MUL, run shift-add for WIDTH edges, then go to DONE; out_valid rises WIDTH cycles after acceptance.
REQ-020 In MUL, in_ready SHALL be 0, and x, y and op SHALL be ignored.
REQ-021 In DONE with out_ready=0, result and flags SHALL be held stable and no operation accepted.
REQ-022 In DONE with out_ready=1 and in_valid=1, the result SHALL be consumed and the new op accepted on the same edge, giving back-to-back throughput of 1 op per cycle.
REQ-023 In DONE with out_ready=1 and in_valid=0, the block SHALL return to IDLE; result and flags keep their last values.
REQ-024 zero SHALL equal (result==0), and neg SHALL equal result[WIDTH-1], for every op.
REQ-025 carry SHALL be: the carry-out for ops 0, 7 and 8; the borrow (unsigned minuend < subtrahend) for ops 1, 2, 9 and 10; operand!=0 for ops 3 and 4; the upper half of the product !=0 for op 14; 0 otherwise.
REQ-026 ovf SHALL be signed overflow for ops 0-4 and 7-10 (e.g. negating the most-negative value, MAX+1, MIN-1), and 0 otherwise.
REQ-027 Op 15, or op 14 with MUL_EN=0, SHALL complete in 1 cycle with result 0, zero=1 and the other flags 0.

Reset
REQ-028 While rst_n=0: state SHALL be IDLE; result, out_valid, zero, neg, carry and ovf SHALL be 0; in_ready SHALL be 0.
REQ-029 Reset asserted during MUL or DONE SHALL abort the operation with no result emitted after release; the first edge after release may accept.

Verification
REQ-030 ADD x=0xFFFF, y=0x0001 -> next cycle: result 0x0000, zero=1, carry=1, ovf=0.
REQ-031 SUB op 1, x=0x8000, y=0x0001 -> result 0x7FFF, ovf=1, carry=0, neg=0; op 2 with the same operands -> result 0x8001, carry=1.
REQ-032 NEG op 3, x=0x8000 -> result 0x8000, ovf=1, neg=1, carry=1; DEC op 9, x=0x0000 -> result 0xFFFF, carry=1.
REQ-033 MUL x=0x0100, y=0x0100 -> in_ready=0 for 16 cycles, then out_valid=1 with result 0x0000, zero=1, carry=1; MUL 0x0007*0x0009 -> 0x003F, carry=0.
REQ-034 Backpressure: result pending, out_ready=0 for 3 cycles, in_valid=1 -> result stable and no accept; out_ready=1 -> consume and accept on the same edge; stream of 4 ADDs -> 4 results on consecutive cycles.
REQ-035 rst_n pulsed low on the 5th cycle of a MUL -> all outputs 0; after release, out_valid stays 0 until a new op is accepted.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// finish on the accepting edge; op 14 runs a WIDTH-step shift-add multiply.
module seq_alu #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mul_hi, mul_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

    logic [WIDTH-1:0] opa, opb, logic_res, alu_res;
    logic             is_sub, is_arith;
    logic [WIDTH:0]   wide;
    logic             alu_c, alu_v;

    assign is_mul   = (MUL_EN != 0) && (op == 4'd14);
    assign mul_last = (cnt == CW'(WIDTH - 1));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nxt = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (mul_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_nxt = is_mul ? MUL : DONE;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand steering: every arithmetic op reduces to a+b or a-b.
    always_comb begin
        opa       = '0;
        opb       = '0;
        is_sub    = 1'b0;
        is_arith  = 1'b0;
        logic_res = '0;
        case (op)
            4'd0:  begin opa = x;  opb = y;   is_arith = 1'b1; end
            4'd1:  begin opa = x;  opb = y;   is_arith = 1'b1; is_sub = 1'b1; end
            4'd2:  begin opa = y;  opb = x;   is_arith = 1'b1; is_sub = 1'b1; end
            4'd3:  begin opa = '0; opb = x;   is_arith = 1'b1; is_sub = 1'b1; end
            4'd4:  begin opa = '0; opb = y;   is_arith = 1'b1; is_sub = 1'b1; end
            4'd5:  logic_res = ~x;
            4'd6:  logic_res = ~y;
            4'd7:  begin opa = x;  opb = ONE; is_arith = 1'b1; end
            4'd8:  begin opa = y;  opb = ONE; is_arith = 1'b1; end
            4'd9:  begin opa = x;  opb = ONE; is_arith = 1'b1; is_sub = 1'b1; end
            4'd10: begin opa = y;  opb = ONE; is_arith = 1'b1; is_sub = 1'b1; end
            4'd11: logic_res = x & y;
            4'd12: logic_res = x | y;
            4'd13: logic_res = x ^ y;
            default: logic_res = '0;
        endcase
    end

    // Bit WIDTH is the carry-out for adds and the borrow (a < b) for subtracts.
    assign wide    = is_sub ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
    assign alu_res = is_arith ? wide[WIDTH-1:0] : logic_res;
    assign alu_c   = is_arith && wide[WIDTH];
    assign alu_v   = is_arith &&
                     ((is_sub ? (opa[WIDTH-1] != opb[WIDTH-1]) : (opa[WIDTH-1] == opb[WIDTH-1])) &&
                      (wide[WIDTH-1] != opa[WIDTH-1]));

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the {carry, high, low} accumulator right by one.
    assign mul_sum    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], mul_lo[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            mcand  <= '0;
            mul_hi <= '0;
            mul_lo <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                if (is_mul) begin
                    mcand  <= x;
                    mul_hi <= '0;
                    mul_lo <= y;
                    cnt    <= '0;
                end else begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    neg    <= alu_res[WIDTH-1];
                    carry  <= alu_c;
                    ovf    <= alu_v;
                end
            end
            if (state == MUL) begin
                mul_hi <= mul_hi_nxt;
                mul_lo <= mul_lo_nxt;
                cnt    <= cnt + CW'(1);
                if (mul_last) begin
                    result <= mul_lo_nxt;
                    zero   <= (mul_lo_nxt == '0);
                    neg    <= mul_lo_nxt[WIDTH-1];
                    carry  <= (mul_hi_nxt != '0);
                    ovf    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a scoreboard queue is filled on every
// accepted op from an independent integer model and drained on every consume.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] x, y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, neg, carry, ovf;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   cons_cyc[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;

    seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Integer reference: unsigned value u decides carry/borrow, signed value s
    // decides overflow.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sbv, u, s, p;
        bit     ar, sub;
        e   = '0;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        u   = 0;
        s   = 0;
        p   = 0;
        ar  = 1'b1;
        sub = 1'b0;
        case (o)
            4'd0:  begin u = ua + ub; s = sa + sbv; end
            4'd1:  begin u = ua - ub; s = sa - sbv; sub = 1'b1; end
            4'd2:  begin u = ub - ua; s = sbv - sa; sub = 1'b1; end
            4'd3:  begin u = 0 - ua;  s = 0 - sa;   sub = 1'b1; end
            4'd4:  begin u = 0 - ub;  s = 0 - sbv;  sub = 1'b1; end
            4'd7:  begin u = ua + 1;  s = sa + 1; end
            4'd8:  begin u = ub + 1;  s = sbv + 1; end
            4'd9:  begin u = ua - 1;  s = sa - 1;   sub = 1'b1; end
            4'd10: begin u = ub - 1;  s = sbv - 1;  sub = 1'b1; end
            default: ar = 1'b0;
        endcase
        if (ar) begin
            e.r = u[W-1:0];
            e.c = sub ? (u < 0) : (u > 65535);
            e.v = (s > 32767) || (s < -32768);
        end else begin
            case (o)
                4'd5:  e.r = ~a;
                4'd6:  e.r = ~b;
                4'd11: e.r = a & b;
                4'd12: e.r = a | b;
                4'd13: e.r = a ^ b;
                4'd14: begin
                    p   = ua * ub;
                    e.r = p[W-1:0];
                    e.c = (p >> 16) != 0;
                end
                default: e.r = '0;
            endcase
        end
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Scoreboard monitor, sampling 1 ns before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                cons_cyc.push_back(cyc);
                tests = tests + 1;
                if (sb.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL scoreboard_unexpected: got result=%h with no pending op", result);
                end else begin
                    e = sb.pop_front();
                    if ({result, zero, neg, carry, ovf} !== {e.r, e.z, e.n, e.c, e.v}) begin
                        fails = fails + 1;
                        $display("FAIL scoreboard: got r=%h z%b n%b c%b v%b, want r=%h z%b n%b c%b v%b",
                                 result, zero, neg, carry, ovf, e.r, e.z, e.n, e.c, e.v);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(op, x, y));
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        op       = o;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #4;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL send_timeout: op %0d never accepted, in_ready=%b want 1", o, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd0; x = 16'h0001; y = 16'h0001;
        #4;
        tests = tests + 1;
        if (in_ready !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tests = tests + 1;
        if ({out_valid, result, zero, neg, carry, ovf} !== '0) begin
            fails = fails + 1;
            $display("FAIL reset_outputs: got ov%b r=%h z%b n%b c%b v%b want all 0",
                     out_valid, result, zero, neg, carry, ovf);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #4;
        tests = tests + 1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL idle_after_reset: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [3:0]   ops[15] = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd4, 4'd7, 4'd10, 4'd5,
                                  4'd6, 4'd11, 4'd12, 4'd13, 4'd8, 4'd15, 4'd3};
        logic [W-1:0] xs[15]  = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h00FF,
                                  16'h1111, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0000, 16'h1234, 16'h0000};
        logic [W-1:0] ys[15]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000,
                                  16'h1234, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFFFF, 16'h5678, 16'h0000};
        // Single-cycle latency on the wrap-around add.
        send(4'd0, 16'hFFFF, 16'h0001);
        in_valid = 1'b0;
        #4;
        tests = tests + 1;
        if (out_valid !== 1'b1 || result !== 16'h0000 || zero !== 1'b1 || carry !== 1'b1 || ovf !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL add_wrap: got ov%b r=%h z%b c%b v%b want ov1 r=0000 z1 c1 v0",
                     out_valid, result, zero, carry, ovf);
        end
        @(negedge clk);
        // Negating the most-negative value.
        send(4'd3, 16'h8000, 16'h0000);
        in_valid = 1'b0;
        #4;
        tests = tests + 1;
        if (result !== 16'h8000 || neg !== 1'b1 || carry !== 1'b1 || ovf !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL neg_min: got r=%h n%b c%b v%b want r=8000 n1 c1 v1", result, neg, carry, ovf);
        end
        @(negedge clk);
        for (int i = 0; i < 15; i++) send(ops[i], xs[i], ys[i]);
        for (int i = 0; i < 40; i++) send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mul;
        bit bad;
        bit found;
        send(4'd14, 16'h0100, 16'h0100);
        in_valid = 1'b0;
        op = 4'd0; x = 16'hDEAD; y = 16'hBEEF;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #4;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tests = tests + 1;
        if (bad) begin
            fails = fails + 1;
            $display("FAIL mul_busy: in_ready/out_valid went high during the 16 busy cycles, want both 0");
        end
        #4;
        tests = tests + 1;
        if (out_valid !== 1'b1 || result !== 16'h0000 || zero !== 1'b1 || carry !== 1'b1 || ovf !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL mul_0100: got ov%b r=%h z%b c%b v%b want ov1 r=0000 z1 c1 v0",
                     out_valid, result, zero, carry, ovf);
        end
        @(negedge clk);
        send(4'd14, 16'h0007, 16'h0009);
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests = tests + 1;
        if (!found || result !== 16'h003F || carry !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL mul_7x9: got ov%b r=%h c%b want ov1 r=003f c0", out_valid, result, carry);
        end
        if (found) @(negedge clk);
        for (int i = 0; i < 4; i++) send(4'd14, 16'($urandom), 16'($urandom));
        send(4'd14, 16'hFFFF, 16'hFFFF);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit bad;
        out_ready = 1'b0;
        send(4'd0, 16'h0001, 16'h0002);
        op = 4'd0; x = 16'h0003; y = 16'h0004;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0003) bad = 1'b1;
            @(negedge clk);
        end
        tests = tests + 1;
        if (bad) begin
            fails = fails + 1;
            $display("FAIL hold_stall: got ov%b in_ready=%b r=%h want ov1 in_ready=0 r=0003 held",
                     out_valid, in_ready, result);
        end
        out_ready = 1'b1;
        #4;
        tests = tests + 1;
        if (in_ready !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL release_ready: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        tests = tests + 1;
        if (out_valid !== 1'b1 || result !== 16'h0007) begin
            fails = fails + 1;
            $display("FAIL same_edge_accept: got ov%b r=%h want ov1 r=0007", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit bad;
        repeat (2) @(negedge clk);
        cons_cyc.delete();
        for (int i = 0; i < 4; i++) send(4'd0, 16'(i * 16'h1111), 16'h0101);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bad = (cons_cyc.size() != 4);
        if (!bad) begin
            for (int k = 1; k < 4; k++) if (cons_cyc[k] != cons_cyc[0] + k) bad = 1'b1;
        end
        tests = tests + 1;
        if (bad) begin
            fails = fails + 1;
            $display("FAIL stream_throughput: got %0d results, want 4 on consecutive cycles", cons_cyc.size());
        end
    endtask

    task automatic test_reset_in_mul;
        bit bad;
        send(4'd0, 16'h1234, 16'h4321);
        send(4'd14, 16'h0003, 16'h0005);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #4;
        tests = tests + 1;
        if ({out_valid, in_ready, result, zero, neg, carry, ovf} !== '0) begin
            fails = fails + 1;
            $display("FAIL reset_mid_mul: got ov%b in_ready=%b r=%h z%b n%b c%b v%b want all 0",
                     out_valid, in_ready, result, zero, neg, carry, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        tests = tests + 1;
        if (in_ready !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL ready_after_release: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tests = tests + 1;
        if (bad) begin
            fails = fails + 1;
            $display("FAIL aborted_mul_output: out_valid rose after reset with no op, want 0");
        end
        send(4'd0, 16'h0005, 16'h0006);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        x         = '0;
        y         = '0;
        #1 rst_n  = 1'b0;
        test_reset;
        test_arith;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_reset_in_mul;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: got %0d pending results, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want natural finish");
        $fatal(1, "watchdog");
    end

endmodule
